mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the single shared memory port between the processor's instruction-fetch path and its load/store path. It issues one memory transaction at a time and tracks its latency. It returns the read data or write acknowledge to the owning requester. A bounded-starvation policy guarantees instruction fetch progress under sustained data traffic. It sits between `PROCESSOR` and `memory`, replacing the direct wiring of their data port.

## Interface
Parameters:
- `ADDR_W`, 16: address width in bits.
- `DATA_W`, 32: data width in bits.
- `MEM_LAT`, 1: memory read latency in cycles, legal range 1–4.
- `STARVE_LIMIT`, 4: maximum consecutive data grants while fetch is waiting, legal range 1–15.

Ports:
- `Clock`  in  1  single clock; all state changes on the posedge.
- `Reset`  in  1  asynchronous, active-high reset.
- `IReq`  in  1  fetch request; held until granted.
- `IAddr`  in  `ADDR_W`  fetch address.
- `IGnt`  out  1  fetch granted this cycle.
- `IValid`  out  1  fetch data valid, one-cycle pulse.
- `IData`  out  `DATA_W`  fetch read data.
- `DReq`  in  1  data request; held until granted.
- `DWrite`  in  1  1 = store, 0 = load.
- `DAddr`  in  `ADDR_W`  data address.
- `DWData`  in  `DATA_W`  store data.
- `DGnt`  out  1  data granted this cycle.
- `DValid`  out  1  load data valid, or store acknowledge; one-cycle pulse.
- `DRData`  out  `DATA_W`  load read data.
- `MemAddr`  out  `ADDR_W`  memory address.
- `MemReadEn`  out  1  memory read strobe.
- `MemWriteEn`  out  1  memory write strobe.
- `MemWData`  out  `DATA_W`  memory write data.
- `MemRData`  in  `DATA_W`  memory read data.

## Operation
- State machine has two states: `ARB_IDLE` (nothing outstanding) and `ARB_WAIT` (one transaction outstanding, latency counter running).
- A grant is allowed in `ARB_IDLE`, or in the response cycle of `ARB_WAIT`.
  - In every other `ARB_WAIT` cycle, `IGnt` and `DGnt` are 0.
  - A grant sets the state to `ARB_WAIT` and loads the latency counter with `MEM_LAT`.
- Arbitration, evaluated only in a cycle where a grant is allowed:
  - Only one request active: that requester wins.
  - Both requests active: D wins, unless the starve counter equals `STARVE_LIMIT`; then I wins.
- Starve counter, 4 bits:
  - Increments on a D grant while `IReq` = 1.
  - Clears on an I grant.
  - Clears in any cycle where `IReq` = 0.
  - Saturates at `STARVE_LIMIT`.
- Grant cycle drives `MemAddr` from the winner.
  - I: `MemReadEn` = 1.
  - D: `MemReadEn` = !`DWrite`, `MemWriteEn` = `DWrite`, `MemWData` = `DWData`.
  - No grant: `MemAddr` = 0, both strobes 0.
- An owner register records I or D for the outstanding transaction.
  - In the response cycle, the owner's `*Valid` pulses.
  - `IData` = `DRData` = `MemRData`; both are qualified only by their `*Valid`.
- Response cycle with no new grant returns the state to `ARB_IDLE`.

## Timing
- `IGnt`, `DGnt` and all `Mem*` outputs are combinational from the requests and the current state, in the same cycle.
- The response cycle is exactly `MEM_LAT` cycles after the grant cycle.
- With `MEM_LAT` = 1, back-to-back grants give one transaction per cycle. In general throughput is one transaction per `MEM_LAT` cycles.
- Stores also pulse `DValid` `MEM_LAT` cycles after grant. `MemWriteEn` is high for exactly one cycle.
- Reset values:
  - State `ARB_IDLE`, counters 0, owner I.
  - `IGnt`, `DGnt`, `IValid`, `DValid`, `MemReadEn`, `MemWriteEn` all 0; `MemAddr` 0.
- Reset asserted mid-transaction drops the outstanding response: no `*Valid` pulse follows reset release.
- Requests that drop before they are granted are simply not serviced; no error is flagged.

## Structure
- Package `mem_arb_pkg` contains:
  - `arb_state_t` {`ARB_IDLE`, `ARB_WAIT`}.
  - `arb_owner_t` {`OWN_I`, `OWN_D`}.
  - Default width constants.
- One sub-module, `mem_arb_starve_ctr`, holds the saturating starve counter and its `at_limit` flag.
- The top level holds the state machine, latency counter, owner register and output muxing. Target size is about 200 lines.

## Test plan
- Fetch only, `MEM_LAT` = 1, `IAddr` = 0x0010: `IGnt` and `MemReadEn` high with `MemAddr` 0x0010 in the same cycle; `IValid` in the next cycle with `IData` = mem[0x0010].
- Both requests held continuously, `STARVE_LIMIT` = 4: grant sequence D,D,D,D,I,D,D,D,D,I.
- Store 0xDEADBEEF to `DAddr` 0x0100, then a load from 0x0100: `MemWriteEn` high for one cycle; `DValid` ack; the load returns `DRData` = 0xDEADBEEF.
- `MEM_LAT` = 3, alternating I and D requests: grants exactly 3 cycles apart; no grant in intermediate cycles; each `*Valid` arrives 3 cycles after its grant.
- `MEM_LAT` = 2, `Reset` pulsed one cycle after an I grant: all outputs 0 immediately; no `IValid` afterwards; first request after release is granted from `ARB_IDLE`.
- `IReq` drops while the starve counter is 3, then returns: counter has cleared, so four more D grants precede the next I grant.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory arbiter.
package mem_arb_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_WAIT = 1'b1
   } arb_state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } arb_owner_t;

   localparam int ARB_ADDR_W   = 16;
   localparam int ARB_DATA_W   = 32;
   // Latency counter must hold MEM_LAT up to 4.
   localparam int ARB_LAT_W    = 3;
   localparam int ARB_STARVE_W = 4;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of data grants handed out while fetch was left waiting.
module mem_arb_starve_ctr
   import mem_arb_pkg::*;
#(
   parameter int LIMIT = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic ireq_i,
   input  logic igrant_i,
   input  logic dgrant_i,
   output logic at_limit_o
);

   localparam logic [ARB_STARVE_W-1:0] LIMIT_C = ARB_STARVE_W'(LIMIT);

   logic [ARB_STARVE_W-1:0] cnt_q, cnt_d;

   // Clear when fetch is served or not asking; otherwise count D wins up to the limit.
   always_comb begin
      cnt_d = cnt_q;
      if (!ireq_i || igrant_i) begin
         cnt_d = '0;
      end else if (dgrant_i && (cnt_q != LIMIT_C)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign at_limit_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter for the shared memory port: fetch vs load/store,
// with bounded starvation of fetch under sustained data traffic.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = ARB_ADDR_W,
   parameter int DATA_W       = ARB_DATA_W,
   parameter int MEM_LAT      = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              IReq,
   input  logic [ADDR_W-1:0] IAddr,
   output logic              IGnt,
   output logic              IValid,
   output logic [DATA_W-1:0] IData,
   input  logic              DReq,
   input  logic              DWrite,
   input  logic [ADDR_W-1:0] DAddr,
   input  logic [DATA_W-1:0] DWData,
   output logic              DGnt,
   output logic              DValid,
   output logic [DATA_W-1:0] DRData,
   output logic [ADDR_W-1:0] MemAddr,
   output logic              MemReadEn,
   output logic              MemWriteEn,
   output logic [DATA_W-1:0] MemWData,
   input  logic [DATA_W-1:0] MemRData
);

   arb_state_t           state_q;
   arb_owner_t           owner_q;
   logic [ARB_LAT_W-1:0] lat_q;

   logic resp;
   logic gnt_ok;
   logic gnt_i;
   logic gnt_d;
   logic at_limit;

   // Response cycle: last cycle of the outstanding transaction's latency.
   assign resp   = (state_q == ARB_WAIT) && (lat_q == ARB_LAT_W'(1));
   // Grants are blocked while Reset is held so outputs go quiet at once.
   assign gnt_ok = !Reset && ((state_q == ARB_IDLE) || resp);

   // D has priority unless fetch has been passed over STARVE_LIMIT times.
   always_comb begin
      gnt_i = gnt_ok && IReq && (!DReq || at_limit);
      gnt_d = gnt_ok && DReq && !(IReq && at_limit);
   end

   mem_arb_starve_ctr #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk_i      (Clock),
      .rst_i      (Reset),
      .ireq_i     (IReq),
      .igrant_i   (gnt_i),
      .dgrant_i   (gnt_d),
      .at_limit_o (at_limit)
   );

   // Transaction FSM: a grant (re)arms the latency counter and records the owner.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= ARB_IDLE;
         lat_q   <= '0;
         owner_q <= OWN_I;
      end else if (gnt_i || gnt_d) begin
         state_q <= ARB_WAIT;
         lat_q   <= ARB_LAT_W'(MEM_LAT);
         owner_q <= gnt_d ? OWN_D : OWN_I;
      end else if (resp) begin
         state_q <= ARB_IDLE;
         lat_q   <= '0;
      end else if (state_q == ARB_WAIT) begin
         lat_q   <= lat_q - 1'b1;
      end
   end

   // Memory-side muxing follows the winner in the grant cycle only.
   always_comb begin
      MemAddr    = '0;
      MemReadEn  = 1'b0;
      MemWriteEn = 1'b0;
      MemWData   = '0;
      if (gnt_i) begin
         MemAddr   = IAddr;
         MemReadEn = 1'b1;
      end else if (gnt_d) begin
         MemAddr    = DAddr;
         MemReadEn  = !DWrite;
         MemWriteEn = DWrite;
         MemWData   = DWData;
      end
   end

   assign IGnt   = gnt_i;
   assign DGnt   = gnt_d;
   assign IValid = resp && (owner_q == OWN_I);
   assign DValid = resp && (owner_q == OWN_D);
   // Read data is shared; each side qualifies it with its own valid.
   assign IData  = MemRData;
   assign DRData = MemRData;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (MEM_LAT 1/3/2) each with a small
// memory model and a response scoreboard fed at grant time.
module tb_mem_arbiter;

   localparam int AW = 16;
   localparam int DW = 32;
   localparam int N  = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;

   logic          rst    [N];
   logic          ireq   [N];
   logic [AW-1:0] iaddr  [N];
   logic          dreq   [N];
   logic          dwrite [N];
   logic [AW-1:0] daddr  [N];
   logic [DW-1:0] dwdata [N];
   logic          ignt   [N];
   logic          ivalid [N];
   logic [DW-1:0] idata  [N];
   logic          dgnt   [N];
   logic          dvalid [N];
   logic [DW-1:0] drdata [N];
   logic [AW-1:0] maddr  [N];
   logic          mre    [N];
   logic          mwe    [N];
   logic [DW-1:0] mwdata [N];
   logic [DW-1:0] mrdata [N];

   logic [DW-1:0] mem [256];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] rd_mem(input logic [AW-1:0] a);
      return mem[a[7:0]];
   endfunction

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_LIMIT(4)) u_dut0 (
      .Clock(clk), .Reset(rst[0]),
      .IReq(ireq[0]), .IAddr(iaddr[0]), .IGnt(ignt[0]), .IValid(ivalid[0]), .IData(idata[0]),
      .DReq(dreq[0]), .DWrite(dwrite[0]), .DAddr(daddr[0]), .DWData(dwdata[0]),
      .DGnt(dgnt[0]), .DValid(dvalid[0]), .DRData(drdata[0]),
      .MemAddr(maddr[0]), .MemReadEn(mre[0]), .MemWriteEn(mwe[0]),
      .MemWData(mwdata[0]), .MemRData(mrdata[0]));

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .STARVE_LIMIT(4)) u_dut1 (
      .Clock(clk), .Reset(rst[1]),
      .IReq(ireq[1]), .IAddr(iaddr[1]), .IGnt(ignt[1]), .IValid(ivalid[1]), .IData(idata[1]),
      .DReq(dreq[1]), .DWrite(dwrite[1]), .DAddr(daddr[1]), .DWData(dwdata[1]),
      .DGnt(dgnt[1]), .DValid(dvalid[1]), .DRData(drdata[1]),
      .MemAddr(maddr[1]), .MemReadEn(mre[1]), .MemWriteEn(mwe[1]),
      .MemWData(mwdata[1]), .MemRData(mrdata[1]));

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2), .STARVE_LIMIT(4)) u_dut2 (
      .Clock(clk), .Reset(rst[2]),
      .IReq(ireq[2]), .IAddr(iaddr[2]), .IGnt(ignt[2]), .IValid(ivalid[2]), .IData(idata[2]),
      .DReq(dreq[2]), .DWrite(dwrite[2]), .DAddr(daddr[2]), .DWData(dwdata[2]),
      .DGnt(dgnt[2]), .DValid(dvalid[2]), .DRData(drdata[2]),
      .MemAddr(maddr[2]), .MemReadEn(mre[2]), .MemWriteEn(mwe[2]),
      .MemWData(mwdata[2]), .MemRData(mrdata[2]));

   typedef struct {
      logic          own_d;
      logic          wr;
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   // Per-instance memory model and scoreboard.
   for (genvar k = 0; k < N; k++) begin : g_mon
      localparam int L = (k == 0) ? 1 : (k == 1) ? 3 : 2;
      logic [DW-1:0] dpipe [4];
      exp_t q[$];

      assign mrdata[k] = dpipe[L-1];

      always @(posedge clk) begin
         if (mwe[k]) mem[maddr[k][7:0]] <= mwdata[k];
         dpipe[0] <= rd_mem(maddr[k]);
         for (int i = 1; i < 4; i++) dpipe[i] <= dpipe[i-1];
      end

      always @(negedge clk) begin
         exp_t e;
         if (rst[k]) begin
            q.delete();
         end else begin
            if (ivalid[k] || dvalid[k]) begin
               chk($sformatf("one_vld%0d", k), 64'(ivalid[k] & dvalid[k]), 0);
               if (q.size() == 0) begin
                  chk($sformatf("spurious_vld%0d", k), 1, 0);
               end else begin
                  e = q.pop_front();
                  chk($sformatf("vld_owner%0d", k), 64'(dvalid[k]), 64'(e.own_d));
                  chk($sformatf("vld_cyc%0d", k), 64'(cyc), 64'(e.due));
                  if (!e.wr) chk($sformatf("rdata%0d", k), ivalid[k] ? idata[k] : drdata[k], e.data);
               end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
               chk($sformatf("missing_vld%0d", k), 0, 1);
               void'(q.pop_front());
            end
            if (ignt[k] || dgnt[k]) begin
               chk($sformatf("one_gnt%0d", k), 64'(ignt[k] & dgnt[k]), 0);
               e.own_d = dgnt[k];
               e.wr    = dgnt[k] & dwrite[k];
               e.due   = cyc + L;
               e.data  = '0;
               if (ignt[k]) begin
                  e.data = rd_mem(iaddr[k]);
                  chk($sformatf("i_mem%0d", k), {mre[k], mwe[k], maddr[k]}, {1'b1, 1'b0, iaddr[k]});
               end else begin
                  if (!dwrite[k]) e.data = rd_mem(daddr[k]);
                  chk($sformatf("d_mem%0d", k), {mre[k], mwe[k], maddr[k]}, {!dwrite[k], dwrite[k], daddr[k]});
                  if (dwrite[k]) chk($sformatf("d_wdata%0d", k), mwdata[k], dwdata[k]);
               end
               q.push_back(e);
            end else begin
               chk($sformatf("idle_mem%0d", k), {mre[k], mwe[k], maddr[k]}, 0);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic byte who(input int k);
      return ignt[k] ? "I" : (dgnt[k] ? "D" : "-");
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      string exp_s;
      byte   g;
      int    last, ngr;
      bit    swap;
      byte   nxt;

      for (int i = 0; i < 256; i++) mem[i] = {16'hC0DE, 8'h00, 8'(i)};
      for (int k = 0; k < N; k++) begin
         rst[k] = 1'b1; ireq[k] = 1'b0; iaddr[k] = '0; dreq[k] = 1'b0;
         dwrite[k] = 1'b0; daddr[k] = '0; dwdata[k] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) rst[k] = 1'b0;

      // Reset state
      @(negedge clk);
      for (int k = 0; k < N; k++)
         chk($sformatf("rst_out%0d", k),
             {ignt[k], dgnt[k], ivalid[k], dvalid[k], mre[k], mwe[k], maddr[k]}, 0);

      // Fetch only, latency 1
      tick();
      ireq[0] = 1'b1; iaddr[0] = 16'h0010;
      @(negedge clk);
      chk("t1_gnt", {ignt[0], mre[0], maddr[0]}, {1'b1, 1'b1, 16'h0010});
      tick();
      ireq[0] = 1'b0;
      @(negedge clk);
      chk("t1_ivalid", 64'(ivalid[0]), 1);
      chk("t1_idata", idata[0], 32'hC0DE0010);

      // Both held: starvation pattern
      tick();
      ireq[0] = 1'b1; iaddr[0] = 16'h0020;
      dreq[0] = 1'b1; dwrite[0] = 1'b0; daddr[0] = 16'h0030;
      exp_s = "DDDDIDDDDI";
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk($sformatf("t2_g%0d", i), 64'(who(0)), 64'(exp_s[i]));
      end
      tick();
      ireq[0] = 1'b0; dreq[0] = 1'b0;
      repeat (3) tick();

      // Store then load back
      dreq[0] = 1'b1; dwrite[0] = 1'b1; daddr[0] = 16'h0100; dwdata[0] = 32'hDEADBEEF;
      @(negedge clk);
      chk("t3_st", {dgnt[0], mwe[0], mwdata[0]}, {1'b1, 1'b1, 32'hDEADBEEF});
      tick();
      dreq[0] = 1'b0; dwrite[0] = 1'b0;
      @(negedge clk);
      chk("t3_we_once", 64'(mwe[0]), 0);
      chk("t3_ack", 64'(dvalid[0]), 1);
      tick();
      dreq[0] = 1'b1; daddr[0] = 16'h0100;
      @(negedge clk);
      chk("t3_ld_gnt", {dgnt[0], mre[0]}, 2'b11);
      tick();
      dreq[0] = 1'b0;
      @(negedge clk);
      chk("t3_ld_vld", 64'(dvalid[0]), 1);
      chk("t3_ld_data", drdata[0], 32'hDEADBEEF);
      repeat (2) tick();

      // IReq drops while starve count is 3
      ireq[0] = 1'b1; iaddr[0] = 16'h0040;
      dreq[0] = 1'b1; dwrite[0] = 1'b0; daddr[0] = 16'h0050;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("t6_pre%0d", i), 64'(who(0)), 64'("D"));
      end
      tick();
      ireq[0] = 1'b0;
      @(negedge clk);
      chk("t6_drop", 64'(who(0)), 64'("D"));
      tick();
      ireq[0] = 1'b1;
      exp_s = "DDDDI";
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("t6_post%0d", i), 64'(who(0)), 64'(exp_s[i]));
      end
      tick();
      ireq[0] = 1'b0; dreq[0] = 1'b0;
      repeat (3) tick();

      // Latency 3, alternating requesters
      ireq[1] = 1'b1; iaddr[1] = 16'h0060; daddr[1] = 16'h0070; dwrite[1] = 1'b0;
      last = -1; ngr = 0; nxt = "I";
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         g = who(1);
         swap = 1'b0;
         if (g != "-") begin
            chk($sformatf("t4_who%0d", ngr), 64'(g), 64'(nxt));
            if (last >= 0) chk($sformatf("t4_gap%0d", ngr), 64'(cyc - last), 3);
            last = cyc;
            ngr++;
            swap = 1'b1;
         end
         tick();
         if (swap) begin
            if (nxt == "I") begin ireq[1] = 1'b0; dreq[1] = 1'b1; nxt = "D"; end
            else            begin dreq[1] = 1'b0; ireq[1] = 1'b1; nxt = "I"; end
         end
      end
      chk("t4_ngr", 64'(ngr), 7);
      ireq[1] = 1'b0; dreq[1] = 1'b0;
      repeat (5) tick();

      // Latency 2, reset one cycle after a fetch grant
      ireq[2] = 1'b1; iaddr[2] = 16'h0080;
      @(negedge clk);
      chk("t5_gnt", 64'(ignt[2]), 1);
      tick();
      rst[2] = 1'b1;
      #1;
      chk("t5_rst_out", {ignt[2], dgnt[2], ivalid[2], dvalid[2], mre[2], mwe[2], maddr[2]}, 0);
      tick();
      rst[2] = 1'b0;
      @(negedge clk);
      chk("t5_no_vld", 64'(ivalid[2]), 0);
      chk("t5_regnt", 64'(ignt[2]), 1);
      tick();
      ireq[2] = 1'b0;
      @(negedge clk);
      chk("t5_wait", 64'(ivalid[2]), 0);
      @(negedge clk);
      chk("t5_vld", 64'(ivalid[2]), 1);
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
